// File: rtl/iob_cmd_initiator.sv
// Single-outstanding IOb initiator: one command in, one IOb transaction, one response out.
// Optional per-transaction timeout is enabled by defining IOB_CMD_INITIATOR_TIMEOUT_EN.
module iob_cmd_initiator #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk_i,
   input  logic                  cke_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [ADDR_W-1:0]     cmd_addr_i,
   input  logic [DATA_W-1:0]     cmd_wdata_i,
   input  logic [DATA_W/8-1:0]   cmd_wstrb_i,
   output logic                  iob_valid_o,
   output logic [ADDR_W-1:0]     iob_addr_o,
   output logic [DATA_W-1:0]     iob_wdata_o,
   output logic [DATA_W/8-1:0]   iob_wstrb_o,
   input  logic                  iob_ready_i,
   input  logic                  iob_rvalid_i,
   input  logic [DATA_W-1:0]     iob_rdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_W-1:0]     rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  busy_o
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t              state_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic [STRB_W-1:0]   wstrb_reg;
   logic [DATA_W-1:0]   rdata_reg;

   if (TIMEOUT < 2) begin : g_timeout_check
      $error("iob_cmd_initiator: TIMEOUT must be at least 2");
   end

`ifdef IOB_CMD_INITIATOR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT);

   logic [CNT_W-1:0]    cnt_reg;
   logic                err_reg;
   logic                timeout_hit;

   assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
   assign rsp_err_o   = err_reg;
`else
   assign rsp_err_o   = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         wdata_reg <= '0;
         wstrb_reg <= '0;
         rdata_reg <= '0;
`ifdef IOB_CMD_INITIATOR_TIMEOUT_EN
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
`endif
      end else if (cke_i) begin
         case (state_reg)
            IDLE: begin
               if (cmd_valid_i) begin
                  addr_reg  <= cmd_addr_i;
                  wdata_reg <= cmd_wdata_i;
                  wstrb_reg <= cmd_wstrb_i;
                  state_reg <= REQ;
`ifdef IOB_CMD_INITIATOR_TIMEOUT_EN
                  cnt_reg   <= '0;
`endif
               end
            end
            REQ: begin
`ifdef IOB_CMD_INITIATOR_TIMEOUT_EN
               cnt_reg <= cnt_reg + CNT_W'(1);
`endif
               // A completion in the last allowed cycle takes precedence over the timeout.
               if (iob_ready_i) begin
                  if (|wstrb_reg) begin
                     rdata_reg <= '0;
`ifdef IOB_CMD_INITIATOR_TIMEOUT_EN
                     err_reg   <= 1'b0;
`endif
                     state_reg <= RESP;
                  end else begin
                     state_reg <= WAIT;
                  end
               end
`ifdef IOB_CMD_INITIATOR_TIMEOUT_EN
               else if (timeout_hit) begin
                  rdata_reg <= '0;
                  err_reg   <= 1'b1;
                  state_reg <= RESP;
               end
`endif
            end
            WAIT: begin
`ifdef IOB_CMD_INITIATOR_TIMEOUT_EN
               cnt_reg <= cnt_reg + CNT_W'(1);
`endif
               if (iob_rvalid_i) begin
                  rdata_reg <= iob_rdata_i;
`ifdef IOB_CMD_INITIATOR_TIMEOUT_EN
                  err_reg   <= 1'b0;
`endif
                  state_reg <= RESP;
               end
`ifdef IOB_CMD_INITIATOR_TIMEOUT_EN
               else if (timeout_hit) begin
                  rdata_reg <= '0;
                  err_reg   <= 1'b1;
                  state_reg <= RESP;
               end
`endif
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Ready is masked while reset or clock-enable would block the accept edge.
   assign cmd_ready_o = (state_reg == IDLE) && cke_i && !rst_i;
   assign iob_valid_o = (state_reg == REQ);
   assign iob_addr_o  = addr_reg;
   assign iob_wdata_o = wdata_reg;
   assign iob_wstrb_o = wstrb_reg;
   assign rsp_valid_o = (state_reg == RESP);
   assign rsp_rdata_o = rdata_reg;
   assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_iob_cmd_initiator.sv
// Self-checking bench for iob_cmd_initiator; responses are checked against a scoreboard queue.
// The timeout scenario runs only when IOB_CMD_INITIATOR_TIMEOUT_EN is defined.
module tb_iob_cmd_initiator;

   logic         clk_i = 1'b0;
   logic         cke_i;
   logic         rst_i;
   logic         cmd_valid_i;
   logic         cmd_ready_o;
   logic [31:0]  cmd_addr_i;
   logic [31:0]  cmd_wdata_i;
   logic [3:0]   cmd_wstrb_i;
   logic         iob_valid_o;
   logic [31:0]  iob_addr_o;
   logic [31:0]  iob_wdata_o;
   logic [3:0]   iob_wstrb_o;
   logic         iob_ready_i;
   logic         iob_rvalid_i;
   logic [31:0]  iob_rdata_i;
   logic         rsp_valid_o;
   logic         rsp_ready_i;
   logic [31:0]  rsp_rdata_o;
   logic         rsp_err_o;
   logic         busy_o;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk_i = ~clk_i;

   iob_cmd_initiator #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (8)
   ) dut (
      .clk_i        (clk_i),
      .cke_i        (cke_i),
      .rst_i        (rst_i),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_addr_i   (cmd_addr_i),
      .cmd_wdata_i  (cmd_wdata_i),
      .cmd_wstrb_i  (cmd_wstrb_i),
      .iob_valid_o  (iob_valid_o),
      .iob_addr_o   (iob_addr_o),
      .iob_wdata_o  (iob_wdata_o),
      .iob_wstrb_o  (iob_wstrb_o),
      .iob_ready_i  (iob_ready_i),
      .iob_rvalid_i (iob_rvalid_i),
      .iob_rdata_i  (iob_rdata_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_rdata_o  (rsp_rdata_o),
      .rsp_err_o    (rsp_err_o),
      .busy_o       (busy_o)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   // All stimulus changes and samples happen on the falling edge.
   task automatic send_cmd(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
      cmd_valid_i = 1'b1;
      cmd_addr_i  = addr;
      cmd_wdata_i = wdata;
      cmd_wstrb_i = wstrb;
      #1;
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL cmd_ready at accept: got %b expected 1", cmd_ready_o);
      end
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
   endtask

   task automatic take_rsp(input string name, input int budget);
      rsp_t e;
      bit   found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         if (rsp_valid_o === 1'b1) begin
            found = 1'b1;
            $display("rsp %s rdata=%h err=%b", name, rsp_rdata_o, rsp_err_o);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL %s unexpected response: got rdata=%h expected none", name, rsp_rdata_o);
            end else begin
               e = exp_q.pop_front();
               if (rsp_rdata_o !== e.rdata) begin
                  failures++;
                  $display("FAIL %s rdata: got %h expected %h", name, rsp_rdata_o, e.rdata);
               end
               checks++;
               if (rsp_err_o !== e.err) begin
                  failures++;
                  $display("FAIL %s err: got %b expected %b", name, rsp_err_o, e.err);
               end
            end
            rsp_ready_i = 1'b1;
            @(negedge clk_i);
            rsp_ready_i = 1'b0;
            #1;
            checks++;
            if (cmd_ready_o !== 1'b1) begin
               failures++;
               $display("FAIL %s cmd_ready after consume: got %b expected 1", name, cmd_ready_o);
            end
         end else begin
            @(negedge clk_i);
         end
      end
      if (!found) begin
         checks++;
         failures++;
         $display("FAIL %s response: got none within %0d cycles expected one", name, budget);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; cke_i = 1'b1; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
      cmd_wstrb_i = '0; iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = '0; rsp_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if (cmd_ready_o !== 1'b0 || iob_valid_o !== 1'b0 || rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL reset flags: got rdy=%b iv=%b rv=%b busy=%b expected 0000",
                  cmd_ready_o, iob_valid_o, rsp_valid_o, busy_o);
      end
      checks++;
      if (iob_addr_o !== 32'h0 || iob_wdata_o !== 32'h0 || iob_wstrb_o !== 4'h0) begin
         failures++;
         $display("FAIL reset iob bus: got %h/%h/%h expected zeros", iob_addr_o, iob_wdata_o, iob_wstrb_o);
      end
      checks++;
      if (rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin
         failures++;
         $display("FAIL reset rsp: got %h/%b expected 0/0", rsp_rdata_o, rsp_err_o);
      end
      rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL release ready: got rdy=%b busy=%b expected 1/0", cmd_ready_o, busy_o);
      end
   endtask

   task automatic test_write();
      int n = 0;
      iob_ready_i = 1'b1;
      send_cmd(32'h8, 32'hA5A5_0001, 4'hF);
      exp_q.push_back('{rdata: 32'h0, err: 1'b0});
      for (int i = 0; i < 10 && iob_valid_o === 1'b1; i++) begin
         n++;
         checks++;
         if (iob_addr_o !== 32'h8 || iob_wdata_o !== 32'hA5A5_0001 || iob_wstrb_o !== 4'hF) begin
            failures++;
            $display("FAIL write bus: got %h/%h/%h expected 00000008/a5a50001/f",
                     iob_addr_o, iob_wdata_o, iob_wstrb_o);
         end
         @(negedge clk_i);
      end
      checks++;
      if (n != 1) begin
         failures++;
         $display("FAIL write valid length: got %0d expected 1", n);
      end
      checks++;
      if (rsp_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL write rsp latency: got %b expected 1", rsp_valid_o);
      end
      iob_ready_i = 1'b0;
      take_rsp("write", 4);
   endtask

   task automatic test_read();
      iob_ready_i = 1'b0;
      send_cmd(32'h4, 32'h1111_2222, 4'h0);
      exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (iob_valid_o !== 1'b1 || iob_addr_o !== 32'h4 || iob_wstrb_o !== 4'h0) begin
            failures++;
            $display("FAIL read req cycle %0d: got v=%b a=%h s=%h expected 1/00000004/0",
                     i, iob_valid_o, iob_addr_o, iob_wstrb_o);
         end
         iob_ready_i  = (i == 3);
         iob_rvalid_i = (i == 0);
         iob_rdata_i  = 32'h0BAD_0BAD;
         @(negedge clk_i);
      end
      iob_ready_i  = 1'b0;
      iob_rvalid_i = 1'b0;
      checks++;
      if (iob_valid_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL read wait: got iv=%b rv=%b expected 0/0", iob_valid_o, rsp_valid_o);
      end
      @(negedge clk_i);
      iob_rvalid_i = 1'b1;
      iob_rdata_i  = 32'hDEAD_BEEF;
      @(negedge clk_i);
      iob_rvalid_i = 1'b0;
      iob_rdata_i  = $urandom;
      checks++;
      if (rsp_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL read rsp latency: got %b expected 1", rsp_valid_o);
      end
      take_rsp("read", 1);
   endtask

   task automatic test_backpressure();
      rsp_t e;
      iob_ready_i = 1'b1;
      send_cmd(32'hC, 32'h0, 4'h0);
      exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
      @(negedge clk_i);
      iob_ready_i  = 1'b0;
      iob_rvalid_i = 1'b1;
      iob_rdata_i  = 32'h1234_5678;
      @(negedge clk_i);
      iob_rvalid_i = 1'b0;
      iob_rdata_i  = 32'hFFFF_0000;
      cmd_valid_i  = 1'b1;
      cmd_addr_i   = 32'h10;
      cmd_wdata_i  = 32'h55;
      cmd_wstrb_i  = 4'h3;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h1234_5678 || cmd_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL backpressure cycle %0d: got rv=%b rd=%h rdy=%b expected 1/12345678/0",
                     i, rsp_valid_o, rsp_rdata_o, cmd_ready_o);
         end
         @(negedge clk_i);
      end
      e = exp_q.pop_front();
      $display("rsp backpressure rdata=%h err=%b", rsp_rdata_o, rsp_err_o);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
         failures++;
         $display("FAIL backpressure rsp: got v=%b rd=%h e=%b expected 1/%h/%b",
                  rsp_valid_o, rsp_rdata_o, rsp_err_o, e.rdata, e.err);
      end
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      #1;
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL backpressure reaccept: got %b expected 1", cmd_ready_o);
      end
      exp_q.push_back('{rdata: 32'h0, err: 1'b0});
      iob_ready_i = 1'b1;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      checks++;
      if (iob_valid_o !== 1'b1 || iob_addr_o !== 32'h10 || iob_wdata_o !== 32'h55 || iob_wstrb_o !== 4'h3) begin
         failures++;
         $display("FAIL queued cmd bus: got v=%b %h/%h/%h expected 1 00000010/00000055/3",
                  iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o);
      end
      @(negedge clk_i);
      iob_ready_i = 1'b0;
      take_rsp("queued_write", 2);
   endtask

   task automatic test_cke_reset();
      iob_ready_i = 1'b1;
      send_cmd(32'h20, 32'h0, 4'h0);
      exp_q.push_back('{rdata: 32'hCAFE_0001, err: 1'b0});
      @(negedge clk_i);
      iob_ready_i = 1'b0;
      cke_i       = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iob_rvalid_i = (i == 1);
         iob_rdata_i  = 32'hBAD0_0000 + i;
         @(negedge clk_i);
         checks++;
         if (busy_o !== 1'b1 || rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL cke hold cycle %0d: got busy=%b rv=%b rdy=%b expected 1/0/0",
                     i, busy_o, rsp_valid_o, cmd_ready_o);
         end
      end
      cke_i        = 1'b1;
      iob_rvalid_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b1) begin
         failures++;
         $display("FAIL missed rvalid: got rv=%b busy=%b expected 0/1", rsp_valid_o, busy_o);
      end
      iob_rvalid_i = 1'b1;
      iob_rdata_i  = 32'hCAFE_0001;
      @(negedge clk_i);
      iob_rvalid_i = 1'b0;
      take_rsp("cke_read", 2);

      iob_ready_i = 1'b0;
      send_cmd(32'h40, 32'h77, 4'hF);
      checks++;
      if (iob_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL rst req: got iv=%b expected 1", iob_valid_o);
      end
      rst_i = 1'b1;
      #1;
      checks++;
      if (cmd_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL rst ready: got %b expected 0", cmd_ready_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || iob_valid_o !== 1'b0 || iob_addr_o !== 32'h0 || rsp_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL rst abort: got busy=%b iv=%b a=%h rv=%b expected 0/0/00000000/0",
                  busy_o, iob_valid_o, iob_addr_o, rsp_valid_o);
      end
      iob_rvalid_i = 1'b1;
      iob_rdata_i  = 32'h7777_7777;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         checks++;
         if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL stale rvalid %0d: got rv=%b busy=%b expected 0/0", i, rsp_valid_o, busy_o);
         end
      end
      iob_rvalid_i = 1'b0;
   endtask

`ifdef IOB_CMD_INITIATOR_TIMEOUT_EN
   task automatic test_timeout();
      int n = 0;
      iob_ready_i = 1'b0;
      send_cmd(32'h30, 32'h0, 4'h0);
      for (int i = 0; i < 20 && iob_valid_o === 1'b1; i++) begin
         n++;
         @(negedge clk_i);
      end
      checks++;
      if (n != 8) begin
         failures++;
         $display("FAIL timeout valid length: got %0d expected 8", n);
      end
      exp_q.push_back('{rdata: 32'h0, err: 1'b1});
      take_rsp("timeout", 2);

      send_cmd(32'h34, 32'h0, 4'h0);
      exp_q.push_back('{rdata: 32'h0BEE_F00D, err: 1'b0});
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (iob_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL late ready cycle %0d: got iv=%b expected 1", i, iob_valid_o);
         end
         iob_ready_i = (i == 7);
         @(negedge clk_i);
      end
      iob_ready_i = 1'b0;
      checks++;
      if (iob_valid_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL late ready wait: got iv=%b rv=%b expected 0/0", iob_valid_o, rsp_valid_o);
      end
      iob_rvalid_i = 1'b1;
      iob_rdata_i  = 32'h0BEE_F00D;
      @(negedge clk_i);
      iob_rvalid_i = 1'b0;
      take_rsp("late_ready", 2);
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_backpressure();
      test_cke_reset();
`ifdef IOB_CMD_INITIATOR_TIMEOUT_EN
      test_timeout();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
